// File: rtl/aes_pkg.sv
// Shared AES definitions: schedule FSM states, Rcon table, configuration check and
// a GF(2^8)-based S-box used by the SubWord logic.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Rcon[i] as a 32-bit word, constant byte in the MSBs; valid for i = 1..10
    function automatic logic [31:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 32'h0100_0000;
            4'd2:    return 32'h0200_0000;
            4'd3:    return 32'h0400_0000;
            4'd4:    return 32'h0800_0000;
            4'd5:    return 32'h1000_0000;
            4'd6:    return 32'h2000_0000;
            4'd7:    return 32'h4000_0000;
            4'd8:    return 32'h8000_0000;
            4'd9:    return 32'h1b00_0000;
            4'd10:   return 32'h3600_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit nr_valid(input int nk, input int nr);
        return (nk == 4 || nk == 6 || nk == 8) && (nr == nk + 6);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 via a short addition chain (0 maps to 0), then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES S-box byte substitution.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] subst
);
    assign subst = sbox(data);
endmodule

// File: rtl/sub_word.sv
// 32-bit SubWord: four parallel S-boxes, purely combinational.
module sub_word (
    input  logic [31:0] word,
    output logic [31:0] subst
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        aes_sbox u_sbox (
            .data  (word[8*b +: 8]),
            .subst (subst[8*b +: 8])
        );
    end
endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES key schedule: one backward word step per cycle, round keys Nr..0 out.
// First key one cycle after start; state and rk freeze while rk_valid && !rk_ready.
module inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = NK + 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [32*NK-1:0] last_key,
    output logic [127:0]    rk,
    output logic [3:0]      rk_round,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic            busy,
    output logic            done
);
    if (!nr_valid(NK, NR)) begin : g_bad_cfg
        $error("inv_key_schedule: NK must be 4, 6 or 8 and NR must equal NK+6");
    end

    localparam logic [5:0] LO_INIT = 6'(4 * (NR + 1) - NK);
    localparam logic [3:0] R_INIT  = 4'(NR);

    state_t      state, state_nxt;
    logic [31:0] win     [NK];
    logic [31:0] win_nxt [NK];
    logic [5:0]  lo, lo_nxt;
    logic [3:0]  r, r_nxt;
    logic        done_nxt;

    // win[0] holds w[lo]; the backward step needs w[j] and w[j-1] at the top
    logic [5:0]  j, j_mod, r4, off;
    logic [3:0]  rcon_idx;
    logic [31:0] prev, sw_in, sw_out, g, new_word;

    assign j        = lo + 6'(NK - 1);
    assign j_mod    = j % 6'(NK);
    assign rcon_idx = 4'(j / 6'(NK));
    assign prev     = win[NK-2];
    assign sw_in    = (j_mod == 6'd0) ? {prev[23:0], prev[31:24]} : prev;

    sub_word u_sub_word (
        .word  (sw_in),
        .subst (sw_out)
    );

    always_comb begin
        g = prev;
        if (j_mod == 6'd0)
            g = sw_out ^ rcon(rcon_idx);
        else if (NK == 8 && j_mod == 6'd4)
            g = sw_out;
    end

    assign new_word = win[NK-1] ^ g;

    assign r4  = {r, 2'b00};
    assign off = r4 - lo;

    always_comb begin
        rk = '0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < NK; i++)
                if (int'(off) + k == i)
                    rk[127-32*k -: 32] = win[i];
    end

    always_comb begin
        state_nxt = state;
        lo_nxt    = lo;
        r_nxt     = r;
        done_nxt  = 1'b0;
        win_nxt   = win;
        case (state)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NK; i++)
                        win_nxt[i] = last_key[32*(NK-i)-1 -: 32];
                    lo_nxt    = LO_INIT;
                    r_nxt     = R_INIT;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (rk_ready) begin
                    if (r == 4'd0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        r_nxt = r - 4'd1;
                        // next round may already sit in the window
                        if (lo > {r - 4'd1, 2'b00})
                            state_nxt = STEP;
                    end
                end
            end
            STEP: begin
                win_nxt[0] = new_word;
                for (int i = 1; i < NK; i++)
                    win_nxt[i] = win[i-1];
                lo_nxt = lo - 6'd1;
                if (lo - 6'd1 == r4)
                    state_nxt = OUT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lo    <= '0;
            r     <= '0;
            done  <= 1'b0;
            for (int i = 0; i < NK; i++)
                win[i] <= '0;
        end else begin
            state <= state_nxt;
            lo    <= lo_nxt;
            r     <= r_nxt;
            done  <= done_nxt;
            for (int i = 0; i < NK; i++)
                win[i] <= win_nxt[i];
        end
    end

    assign rk_round = r;
    assign rk_valid = (state == OUT);
    assign busy     = (state != IDLE);

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Reverse AES key schedule for the decryption datapath. Given the last Nk words of the expanded key, it walks the FIPS-197 schedule backwards one word per cycle. It emits the 128-bit round keys in decryption order, round Nr down to round 0, over a valid/ready stream. The block sits between key storage and the inverse-cipher round engine, so the full expanded key never has to be buffered.

## Interface
- Nk, 4: key length in 32-bit words; legal values are 4, 6 and 8.
- Nr, Nk+6: number of rounds; must equal Nk+6.
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a schedule. Sampled only in IDLE.
- last_key  in  32*Nk  expanded-key words w[4(Nr+1)-Nk] .. w[4(Nr+1)-1]. The lowest-index word is in the MSBs. Sampled on the start cycle.
- rk  out  128  current round key, words w[4r] .. w[4r+3], with w[4r] in the MSBs.
- rk_round  out  4  round index r of rk.
- rk_valid  out  1  rk and rk_round are valid.
- rk_ready  in  1  consumer accepts rk when rk_valid && rk_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after round 0 is accepted.

## Operation
- State kept: window W of Nk words holding w[lo] .. w[lo+Nk-1], a word index lo, and a round counter r.
- Backward step, with j = lo+Nk-1:
  - Compute w[lo-1] = w[j] ^ g(w[j-1]).
  - g(x) = SubWord(RotWord(x)) ^ Rcon[j/Nk] when j mod Nk == 0.
  - g(x) = SubWord(x) when Nk == 8 and j mod Nk == 4.
  - Otherwise g(x) = x.
  - The window then shifts: w[j] is dropped, w[lo-1] enters at the bottom, and lo decrements.
- rk is a combinational select of W at word offset 4r-lo. W and r are frozen while rk_valid is high, so rk is stable until accepted.
- States:
  - IDLE: on start, load W ← last_key, lo ← 4(Nr+1)-Nk, r ← Nr, then go to OUT. Round Nr is always contained in the initial window.
  - OUT, no handshake: hold all state.
  - OUT, handshake with r == 0: go to IDLE and pulse done.
  - OUT, handshake with r > 0: r ← r-1. If lo ≤ 4(r-1), stay in OUT (back-to-back emission); otherwise go to STEP.
  - STEP: one backward step per cycle. On the cycle the new lo equals 4r, go to OUT.
- Rcon index range: 1..10 for Nk=4, 1..8 for Nk=6, 1..7 for Nk=8.
- Total backward steps per schedule: 40 for Nk=4, 46 for Nk=6, 52 for Nk=8.

## Timing
- Reset value: all outputs 0 (rk_round=0, rk=0), state IDLE, W=0, lo=0, r=0.
- rst overrides everything, including mid-schedule. Any round key not yet accepted is discarded.
- Start to first output: start is sampled at edge 0; rk_valid is high after edge 1 with rk_round = Nr.
- start is ignored while busy. start and rst in the same cycle: reset wins.
- Gap between rounds with rk_ready held high:
  - Nk=4: 4 STEP cycles plus 1 OUT cycle per round.
  - Nk=8: pairs of rounds are emitted back-to-back.
  - Nk=6: gaps vary with window alignment.
- Full schedule with rk_ready held high, Nk=4: done pulses 1 + 40 + 11 = 52 edges after start.
- rk_ready low: the FSM holds in OUT indefinitely and no backward steps occur.
- busy falls in the same cycle done pulses. A new start is accepted from the next cycle.

## Structure
- Shared package aes_pkg holds:
  - The Rcon table, indexed 1..10 as 32-bit words with the byte in the MSBs.
  - A function that checks Nr from Nk.
  - The state enum: IDLE, STEP, OUT.
- Sub-module sub_word: four instances of the shared aes_sbox, one 32-bit SubWord.
  - A single instance serves both g() cases; RotWord is applied ahead of it via a mux.

## Test plan
- Nk=4, last_key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, rk_ready high:
  - round 10 = last_key, round 1 = a0fafe17 88542cb1 23a33939 2a6c7605, round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - done pulses 52 edges after start.
- Nk=6 and Nk=8 with the FIPS-197 C.2/C.3 keys: all 13 (Nk=6) or 15 (Nk=8) round keys match a software forward expansion, in reverse order. Check rk_round on every beat.
- Nk=4, rk_ready toggled randomly: rk and rk_round stay stable while valid && !ready, and no round is dropped or duplicated.
- rst asserted during round 5 emission: next cycle all outputs are 0 and busy is 0. A fresh start then produces a correct full sequence.
- start pulsed while busy: ignored, with no change to the sequence. start in the same cycle as rst: no schedule begins.
- Back-to-back schedules: start is asserted the cycle after done, and the second sequence is correct.
